// File: rtl/ext_trig_pkg.sv
// Shared definitions for the external trigger line controller: TX state
// encoding, default timing parameters and the idle levels of the inputs.
package ext_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HOLDOFF = 2'd3
  } txState_e;

  localparam int DEF_TX_WIDTH = 8;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_HOLDOFF  = 16;
  localparam int DEF_RX_WIDTH = 8;
  localparam int DEF_CNT_W    = 16;

  // Levels the synchronizers hold in reset: the MAROC trigger is active
  // high so it idles low, the shared line is active low so it idles high.
  localparam logic PIXEL_INACTIVE = 1'b0;
  localparam logic LINE_INACTIVE  = 1'b1;

  // Largest of three timing parameters, used to size the shared TX timer.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ext_trig_ctrl_sync.sv
// Two-flop synchronizer followed by a registered edge detector. The reset
// level matches the idle level of the input so that leaving reset never
// produces a spurious edge; FALLING selects which transition is reported.
module trig_sync
  import ext_trig_pkg::*;
#(
  parameter logic RST_LEVEL = PIXEL_INACTIVE,
  parameter bit   FALLING   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_q;
  logic edge_d;

  // Compare the synchronized value with its previous sample.
  always_comb begin
    edge_d = FALLING ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);
  end

  // Synchronizer chain, history flop and registered one-cycle edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_LEVEL;
      sync2_q <= RST_LEVEL;
      prev_q  <= RST_LEVEL;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/ext_trig_ctrl.sv
// External trigger line controller. Drives the shared active-low line for
// local MAROC triggers, stretches remote line edges into a MAROC trigger
// pulse, masks the echo of its own drive, and counts tx/rx/dropped events.
module ext_trig_ctrl
  import ext_trig_pkg::*;
#(
  parameter int TX_WIDTH = DEF_TX_WIDTH,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int HOLDOFF  = DEF_HOLDOFF,
  parameter int RX_WIDTH = DEF_RX_WIDTH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_trig_maroc,
  input  logic             ext_trig_o,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic             cnt_clr,
  output logic             ext_trig_t,
  output logic             ext_trig_maroc,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int TMR_W = $clog2(maxOf3(TX_WIDTH, SETTLE, HOLDOFF) + 1);
  localparam int RX_W  = $clog2(RX_WIDTH + 1);

  // Timer holds "remaining cycles minus one" of the current phase.
  localparam logic [TMR_W-1:0] TX_LOAD     = TMR_W'(TX_WIDTH - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [RX_W-1:0]  RX_LOAD     = RX_W'(RX_WIDTH);

  logic localEv;
  logic remoteEv;

  txState_e         state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [RX_W-1:0]  rxCnt_q, rxCnt_d;
  logic [CNT_W-1:0] txCount_q, txCount_d;
  logic [CNT_W-1:0] rxCount_q, rxCount_d;
  logic [CNT_W-1:0] dropCount_q, dropCount_d;
  logic             trigT_q, maroc_q, busy_q;
  logic             txInc, dropInc, rxAccept;

  trig_sync #(
    .RST_LEVEL (PIXEL_INACTIVE),
    .FALLING   (1'b0)
  ) u_pixelSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (pixel_trig_maroc),
    .edge_o  (localEv)
  );

  trig_sync #(
    .RST_LEVEL (LINE_INACTIVE),
    .FALLING   (1'b1)
  ) u_lineSync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_trig_o),
    .edge_o  (remoteEv)
  );

  // TX sequencing: drive, let the line settle, then hold off new triggers.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    txInc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (localEv && tx_en) begin
          state_d = ST_DRIVE;
          timer_d = TX_LOAD;
          txInc   = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_q == '0) begin
          state_d = ST_RELEASE;
          timer_d = SETTLE_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_RELEASE: begin
        if (timer_q == '0) begin
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            timer_d = HOLD_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RX stretch: remote edges accepted only when the line is not ours and
  // no stretch is running; a simultaneous local trigger takes precedence.
  always_comb begin
    dropInc  = localEv & ~txInc;
    rxAccept = remoteEv && rx_en && (rxCnt_q == '0) && !txInc &&
               ((state_q == ST_IDLE) || (state_q == ST_HOLDOFF));
    if (rxAccept) begin
      rxCnt_d = RX_LOAD;
    end else if (rxCnt_q != '0) begin
      rxCnt_d = rxCnt_q - RX_W'(1);
    end else begin
      rxCnt_d = rxCnt_q;
    end
  end

  // Event counters wrap naturally; a clear wins over a same-cycle increment.
  always_comb begin
    txCount_d   = cnt_clr ? '0 : txCount_q   + CNT_W'(txInc);
    rxCount_d   = cnt_clr ? '0 : rxCount_q   + CNT_W'(rxAccept);
    dropCount_d = cnt_clr ? '0 : dropCount_q + CNT_W'(dropInc);
  end

  // State, counters and outputs; outputs are decoded from next state so the
  // pad enable and MAROC trigger come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      rxCnt_q     <= '0;
      txCount_q   <= '0;
      rxCount_q   <= '0;
      dropCount_q <= '0;
      trigT_q     <= 1'b1;
      maroc_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rxCnt_q     <= rxCnt_d;
      txCount_q   <= txCount_d;
      rxCount_q   <= rxCount_d;
      dropCount_q <= dropCount_d;
      trigT_q     <= (state_d != ST_DRIVE);
      maroc_q     <= (state_d == ST_DRIVE) || (rxCnt_d != '0);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign ext_trig_t     = trigT_q;
  assign ext_trig_maroc = maroc_q;
  assign busy           = busy_q;
  assign tx_count       = txCount_q;
  assign rx_count       = rxCount_q;
  assign drop_count     = dropCount_q;

endmodule

// File: tb/tb_ext_trig_ctrl.sv
// Testbench for ext_trig_ctrl: directed trigger scenarios checked against a
// timestamp-based model of the line protocol plus hand-computed pulse edges.
module tb_ext_trig_ctrl;

  localparam int TX_WIDTH = 8;
  localparam int SETTLE   = 4;
  localparam int HOLDOFF  = 16;
  localparam int RX_WIDTH = 8;
  localparam int CNT_W    = 16;

  localparam int PH_IDLE    = 0;
  localparam int PH_DRIVE   = 1;
  localparam int PH_RELEASE = 2;
  localparam int PH_HOLD    = 3;

  logic clk = 1'b0;
  logic rst;
  logic pixelTrig;
  logic remoteLow;
  logic txEn;
  logic rxEn;
  logic cntClr;
  logic extTrigO;
  logic extTrigT;
  logic extTrigMaroc;
  logic busy;
  logic [CNT_W-1:0] txCount;
  logic [CNT_W-1:0] rxCount;
  logic [CNT_W-1:0] dropCount;

  int vectors = 0;
  int miscompares = 0;

  // Model state: times are posedge indices.
  int cyc = 0;
  int txStart = -1000;
  int rxStart = -1000;
  bit modelValid = 1'b0;
  logic mT = 1'b1;
  logic mMaroc = 1'b0;
  logic mBusy = 1'b0;
  logic [CNT_W-1:0] mTx = '0;
  logic [CNT_W-1:0] mRx = '0;
  logic [CNT_W-1:0] mDrop = '0;
  bit pixH[5];
  bit lineH[5];
  int lowCount = 0;
  int lowBase;

  always #5 clk = ~clk;

  // Shared open-drain line: low when the remote board or the DUT pulls it.
  assign extTrigO = remoteLow ? 1'b0 : extTrigT;

  ext_trig_ctrl #(
    .TX_WIDTH (TX_WIDTH),
    .SETTLE   (SETTLE),
    .HOLDOFF  (HOLDOFF),
    .RX_WIDTH (RX_WIDTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_trig_maroc (pixelTrig),
    .ext_trig_o       (extTrigO),
    .tx_en            (txEn),
    .rx_en            (rxEn),
    .cnt_clr          (cntClr),
    .ext_trig_t       (extTrigT),
    .ext_trig_maroc   (extTrigMaroc),
    .busy             (busy),
    .tx_count         (txCount),
    .rx_count         (rxCount),
    .drop_count       (dropCount)
  );

  function automatic int phaseAt(input int t);
    if (t < txStart) return PH_IDLE;
    if (t < txStart + TX_WIDTH) return PH_DRIVE;
    if (t < txStart + TX_WIDTH + SETTLE) return PH_RELEASE;
    if (t < txStart + TX_WIDTH + SETTLE + HOLDOFF) return PH_HOLD;
    return PH_IDLE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model step at each rising edge: events appear three edges after the
  // input sample that forms them; expected outputs follow from timestamps.
  task automatic modelStep();
    bit lineNow, locEv, remEv, txTake;
    int prevPh, ph;
    cyc++;
    lineNow = remoteLow ? 1'b0 : mT;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        pixH[i] = 1'b0;
        lineH[i] = 1'b1;
      end
      txStart = -1000;
      rxStart = -1000;
      mTx = '0;
      mRx = '0;
      mDrop = '0;
      modelValid = 1'b1;
    end else begin
      for (int i = 4; i > 0; i--) begin
        pixH[i] = pixH[i-1];
        lineH[i] = lineH[i-1];
      end
      pixH[0] = pixelTrig;
      lineH[0] = lineNow;
      locEv = pixH[3] & ~pixH[4];
      remEv = ~lineH[3] & lineH[4];
      prevPh = phaseAt(cyc - 1);
      txTake = (prevPh == PH_IDLE) && locEv && txEn;
      if (txTake) begin
        txStart = cyc;
        mTx++;
      end else if (locEv) begin
        mDrop++;
      end
      if (remEv && !txTake && rxEn && (prevPh == PH_IDLE || prevPh == PH_HOLD) &&
          (cyc - 1 >= rxStart + RX_WIDTH)) begin
        rxStart = cyc;
        mRx++;
      end
      if (cntClr) begin
        mTx = '0;
        mRx = '0;
        mDrop = '0;
      end
    end
    ph = phaseAt(cyc);
    mT = (ph != PH_DRIVE);
    mMaroc = (ph == PH_DRIVE) || (cyc < rxStart + RX_WIDTH);
    mBusy = (ph != PH_IDLE);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Compare every output against the model half a cycle after each edge.
  initial begin
    forever begin
      @(negedge clk);
      if (extTrigT === 1'b0) lowCount++;
      if (modelValid) begin
        checkOutput("model_t", extTrigT, mT);
        checkOutput("model_maroc", extTrigMaroc, mMaroc);
        checkOutput("model_busy", busy, mBusy);
        checkOutput("model_txcnt", txCount, mTx);
        checkOutput("model_rxcnt", rxCount, mRx);
        checkOutput("model_dropcnt", dropCount, mDrop);
      end
    end
  end

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic pix, input logic remLow, input int hold);
    pixelTrig = pix;
    remoteLow = remLow;
    waitCyc(hold);
  endtask

  task automatic clearCounters();
    cntClr = 1'b1;
    waitCyc(1);
    cntClr = 1'b0;
    waitCyc(1);
  endtask

  initial begin
    rst = 1'b1;
    pixelTrig = 1'b0;
    remoteLow = 1'b0;
    txEn = 1'b1;
    rxEn = 1'b1;
    cntClr = 1'b0;
    waitCyc(3);
    checkOutput("reset_t", extTrigT, 1);
    checkOutput("reset_maroc", extTrigMaroc, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_txcnt", txCount, 0);
    rst = 1'b0;
    waitCyc(5);

    // Local trigger: line low from k+3 for 8 cycles, own echo not counted.
    $display("[TB] local trigger");
    applyStimulus(1, 0, 3);
    checkOutput("loc_t_k2", extTrigT, 1);
    applyStimulus(0, 0, 1);
    checkOutput("loc_t_k3", extTrigT, 0);
    checkOutput("loc_maroc_k3", extTrigMaroc, 1);
    waitCyc(7);
    checkOutput("loc_t_k10", extTrigT, 0);
    waitCyc(1);
    checkOutput("loc_t_k11", extTrigT, 1);
    waitCyc(30);
    checkOutput("loc_txcnt", txCount, 1);
    checkOutput("loc_rxcnt", rxCount, 0);

    // Remote trigger stretched to 8 cycles; second edge inside is ignored.
    $display("[TB] remote trigger");
    clearCounters();
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 1);
    checkOutput("rem_maroc_k2", extTrigMaroc, 0);
    waitCyc(1);
    checkOutput("rem_maroc_k3", extTrigMaroc, 1);
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 5);
    checkOutput("rem_maroc_k10", extTrigMaroc, 1);
    waitCyc(1);
    checkOutput("rem_maroc_k11", extTrigMaroc, 0);
    waitCyc(10);
    checkOutput("rem_rxcnt", rxCount, 1);
    checkOutput("rem_t", extTrigT, 1);

    // Local triggers 10 apart (second dropped), then 30 apart (both taken).
    $display("[TB] trigger spacing");
    clearCounters();
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 7);
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 40);
    checkOutput("gap10_txcnt", txCount, 1);
    checkOutput("gap10_dropcnt", dropCount, 1);
    clearCounters();
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 27);
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 40);
    checkOutput("gap30_txcnt", txCount, 2);
    checkOutput("gap30_dropcnt", dropCount, 0);

    // Simultaneous local and remote: local wins, remote not counted.
    $display("[TB] simultaneous events");
    clearCounters();
    applyStimulus(1, 1, 3);
    applyStimulus(0, 0, 1);
    checkOutput("sim_maroc_k3", extTrigMaroc, 1);
    checkOutput("sim_t_k3", extTrigT, 0);
    waitCyc(7);
    checkOutput("sim_maroc_k10", extTrigMaroc, 1);
    waitCyc(1);
    checkOutput("sim_maroc_k11", extTrigMaroc, 0);
    waitCyc(30);
    checkOutput("sim_rxcnt", rxCount, 0);
    checkOutput("sim_txcnt", txCount, 1);

    // Remote accepted during holdoff.
    $display("[TB] remote in holdoff");
    clearCounters();
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 13);
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 40);
    checkOutput("hold_rxcnt", rxCount, 1);

    // Reset in the third DRIVE cycle releases the line at the next edge.
    $display("[TB] reset during drive");
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 3);
    rst = 1'b1;
    waitCyc(1);
    checkOutput("rst_t", extTrigT, 1);
    checkOutput("rst_maroc", extTrigMaroc, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_txcnt", txCount, 0);
    checkOutput("rst_rxcnt", rxCount, 0);
    checkOutput("rst_dropcnt", dropCount, 0);
    rst = 1'b0;
    waitCyc(5);

    // Clear on the same edge as a tx increment leaves the counter at zero.
    $display("[TB] clear priority");
    applyStimulus(1, 0, 3);
    pixelTrig = 1'b0;
    cntClr = 1'b1;
    waitCyc(1);
    cntClr = 1'b0;
    checkOutput("clr_txcnt", txCount, 0);
    checkOutput("clr_t", extTrigT, 0);
    waitCyc(30);

    // tx_en low: every local edge dropped, line never driven.
    $display("[TB] tx disabled");
    clearCounters();
    txEn = 1'b0;
    lowBase = lowCount;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 2);
      applyStimulus(0, 0, 3);
    end
    waitCyc(5);
    checkOutput("txdis_dropcnt", dropCount, 3);
    checkOutput("txdis_txcnt", txCount, 0);
    checkOutput("txdis_lowcycles", lowCount - lowBase, 0);

    // tx_en removed mid-drive: the pulse still runs its full width.
    $display("[TB] tx_en dropped mid-drive");
    txEn = 1'b1;
    lowBase = lowCount;
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 3);
    txEn = 1'b0;
    waitCyc(5);
    checkOutput("mid_t_k10", extTrigT, 0);
    waitCyc(1);
    checkOutput("mid_t_k11", extTrigT, 1);
    waitCyc(30);
    checkOutput("mid_lowcycles", lowCount - lowBase, 8);
    txEn = 1'b1;
    waitCyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
